sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//  Synthesizable responder for the 16-bit external SRAM bus driven by our memory controller.
//  Emulates the off-chip SRAM with on-chip RAM: accepts byte-masked writes, returns read data
//  on the shared DQ bus after a configurable latency, and keeps access/error statistics.
//  Sits on the SRAM pins in place of the chip, for FPGA bring-up and closed-loop controller tests.
// PARAMETERS
//  ADDR_W    10  word-address bits implemented; depth = 2**ADDR_W 16-bit words (1..18)
//  READ_LAT  0   read latency in clk cycles (0..4); 0 = combinational read, like the real chip
//  OOR_DATA  16'h0000  value returned for out-of-range reads
// PORTS
//  clk           in     1   system clock, all state on rising edge
//  rst           in     1   synchronous, active-high reset
//  SRAM_DQ       inout  16  shared data bus; driven only during a valid read, else 'z
//  SRAM_adr      in     18  word address
//  SRAM_UB_N     in     1   upper byte lane enable, active low
//  SRAM_LB_N     in     1   lower byte lane enable, active low
//  SRAM_WE_N     in     1   write enable, active low
//  SRAM_CE_N     in     1   chip enable, active low
//  SRAM_OE_N     in     1   output enable, active low
//  wr_count      out    16  accepted write cycles, saturates at 16'hFFFF
//  rd_count      out    16  accepted read cycles, saturates at 16'hFFFF
//  oor_err       out    1   sticky: any access with SRAM_adr[17:ADDR_W] != 0
//  bus_conflict  out    1   sticky: write cycle while a read return was due
// BEHAVIOUR
//  - Reset (rst=1 at posedge): read pipeline valids cleared, DQ released ('z), wr_count=0,
//    rd_count=0, oor_err=0, bus_conflict=0. Memory contents are NOT cleared. rst overrides all.
//  - Cycle classes (sampled each posedge): CE_N=1 -> idle; CE_N=0&WE_N=0 -> write;
//    CE_N=0&WE_N=1 -> read request. OE_N does not affect classification.
//  - Write: mem[adr[ADDR_W-1:0]][15:8] <= DQ[15:8] if UB_N=0; [7:0] <= DQ[7:0] if LB_N=0.
//    Both lanes masked still counts as a write. Out-of-range write: dropped, oor_err<=1.
//  - Read data word: mem[idx] at request time, masked lanes (UB_N/LB_N=1) forced to 8'h00;
//    out-of-range -> OOR_DATA and oor_err<=1. Write-then-read same address returns new data.
//  - READ_LAT=0: DQ = read word combinationally whenever CE_N=0, WE_N=1, OE_N=0; else 'z.
//  - READ_LAT=L>0: L-deep shift pipe of {valid,data}; request in cycle N returns in cycle N+L.
//    DQ driven in cycle N+L iff pipe valid and CE_N=0, WE_N=1, OE_N=0 in that cycle; else 'z
//    and the return is discarded (not retried). Back-to-back requests give one word per cycle.
//  - Conflict: WE_N=0 & CE_N=0 while a return is due -> DQ 'z (controller wins the bus),
//    write performed, return discarded, bus_conflict<=1.
//  - Counters increment by 1 per accepted cycle, one per cycle max, hold at 16'hFFFF.
//  - Responder never drives DQ during a write cycle or in the cycle rst is high.
// TESTING
//  1 L=0: write 16'h1234 adr 5 UB_N=LB_N=0, then read adr 5 OE_N=0 -> DQ=16'h1234 same cycle; wr_count=1, rd_count=1.
//  2 Byte lanes: write 16'hABCD adr 5 UB_N=0,LB_N=1 -> read adr 5 = 16'hAB34; read with LB_N=1 -> 16'hAB00.
//  3 L=2: read adr 5 in cycle N -> DQ 'z at N,N+1, 16'hAB34 at N+2; 4 back-to-back reads -> 4 consecutive words.
//  4 ADDR_W=10: write adr 18'h00400 -> mem unchanged, oor_err=1; read same adr -> OOR_DATA.
//  5 Closed loop with memory controller: 32-bit write 32'hDEADBEEF at byte adr 1024 -> words 0/1 = BEEF/DEAD; readback = 32'hDEADBEEF.
//  6 L=2: read in N, WE_N=0 in N+2 -> DQ 'z, bus_conflict=1; rst in N+1 of another read -> DQ 'z at N+2, counters 0, mem kept.

Source files
------------

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - SRAM control/address pins seen by the responder
// Purpose: bundles the controller-driven SRAM address and strobe pins.
// Signals: SRAM_adr (18-bit word address), SRAM_UB_N / SRAM_LB_N (byte lanes),
//          SRAM_WE_N, SRAM_CE_N, SRAM_OE_N (all active low).
// Modports: master = memory controller side, slave = responder side.
// The tristate data bus stays a plain inout on the responder.
interface sram_if;
  logic [17:0] SRAM_adr;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_WE_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  modport master (
    output SRAM_adr, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input SRAM_adr, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - on-chip RAM standing in for the external 16-bit SRAM
// Purpose: accepts byte-masked writes, returns reads on SRAM_DQ after READ_LAT
//          cycles, and keeps access and error statistics.
// Ports: clk, rst (synchronous, active high)
//        bus          sram_if.slave: address, lane enables, WE_N/CE_N/OE_N
//        SRAM_DQ      shared data bus, driven only while a read return is presented
//        wr_count     saturating count of write cycles
//        rd_count     saturating count of read request cycles
//        oor_err      sticky: access beyond the implemented depth
//        bus_conflict sticky: write cycle while a read return was due
module sram_responder #(
  parameter int          ADDR_W   = 10,
  parameter int          READ_LAT = 0,
  parameter logic [15:0] OOR_DATA = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  sram_if.slave       bus,
  inout  wire  [15:0] SRAM_DQ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        oor_err,
  output logic        bus_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0]       mem [DEPTH];
  logic              is_wr;
  logic              is_rd;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       raw;
  logic [15:0]       rd_word;
  logic              ret_due;
  logic [15:0]       ret_data;
  logic              dq_oe;

  // OE_N only gates the output driver, never the cycle class.
  assign is_wr    = ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
  assign is_rd    = ~bus.SRAM_CE_N &  bus.SRAM_WE_N;
  assign in_range = (bus.SRAM_adr >> ADDR_W) == 18'd0;
  assign idx      = bus.SRAM_adr[ADDR_W-1:0];
  assign raw      = mem[idx];

  // Read word as seen at request time; disabled lanes read back as zero.
  always_comb begin
    rd_word = OOR_DATA;
    if (in_range) begin
      rd_word[15:8] = bus.SRAM_UB_N ? 8'h00 : raw[15:8];
      rd_word[7:0]  = bus.SRAM_LB_N ? 8'h00 : raw[7:0];
    end
  end

  // Memory has no reset so contents survive rst, but no write lands while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && is_wr && in_range) begin
      if (!bus.SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
      if (!bus.SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb
      // Zero latency behaves like the real chip: the return is the live request.
      assign ret_due  = is_rd;
      assign ret_data = rd_word;
    end else begin : g_pipe
      logic [READ_LAT-1:0] pipe_v;
      logic [15:0]         pipe_d [READ_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_v <= '0;
        end else begin
          pipe_v[0] <= is_rd;
          for (int i = 1; i < READ_LAT; i++) pipe_v[i] <= pipe_v[i-1];
        end
        pipe_d[0] <= rd_word;
        for (int i = 1; i < READ_LAT; i++) pipe_d[i] <= pipe_d[i-1];
      end

      // A return that is not picked up in its cycle simply falls off the end.
      assign ret_due  = pipe_v[READ_LAT-1];
      assign ret_data = pipe_d[READ_LAT-1];
    end
  endgenerate

  // Drive only when the controller is reading with outputs enabled; a write
  // cycle therefore always leaves the bus to the controller.
  assign dq_oe   = ret_due & is_rd & ~bus.SRAM_OE_N & ~rst;
  assign SRAM_DQ = dq_oe ? ret_data : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count     <= 16'h0000;
      rd_count     <= 16'h0000;
      oor_err      <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      if (is_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (is_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if ((is_wr || is_rd) && !in_range) oor_err <= 1'b1;
      if (is_wr && ret_due) bus_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed checks of sram_responder at latency 0 and 2
module tb_sram_responder;

  logic        clk;
  logic        rst;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  wire  [15:0] dq0;
  wire  [15:0] dq2;
  logic [15:0] wr0, rd0, wr2, rd2;
  logic        oor0, cf0, oor2, cf2;
  int          n_checks;
  int          n_errors;

  sram_if bus ();

  // Released bus bits float high, so 16'hFFFF means nobody drives.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu0 (dq0[i]);
    pullup pu2 (dq2[i]);
  end

  assign dq0 = tb_dq_en ? tb_dq : 'z;
  assign dq2 = tb_dq_en ? tb_dq : 'z;

  sram_responder #(.ADDR_W(10), .READ_LAT(0), .OOR_DATA(16'h0000)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq0),
    .wr_count(wr0), .rd_count(rd0), .oor_err(oor0), .bus_conflict(cf0)
  );

  sram_responder #(.ADDR_W(10), .READ_LAT(2), .OOR_DATA(16'h0000)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq2),
    .wr_count(wr2), .rd_count(rd2), .oor_err(oor2), .bus_conflict(cf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_bus(input logic ce_n, input logic we_n, input logic oe_n,
                         input logic ub_n, input logic lb_n,
                         input logic [17:0] adr, input logic [15:0] wdata);
    bus.SRAM_CE_N = ce_n;
    bus.SRAM_WE_N = we_n;
    bus.SRAM_OE_N = oe_n;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    bus.SRAM_adr  = adr;
    tb_dq         = wdata;
    tb_dq_en      = !ce_n && !we_n && !(ub_n && lb_n);
    #1;
  endtask

  task automatic wr(input logic [17:0] adr, input logic [15:0] d, input logic ub_n, input logic lb_n);
    set_bus(1'b0, 1'b0, 1'b1, ub_n, lb_n, adr, d);
  endtask

  task automatic rd(input logic [17:0] adr, input logic ub_n, input logic lb_n);
    set_bus(1'b0, 1'b1, 1'b0, ub_n, lb_n, adr, 16'h0000);
  endtask

  task automatic idle();
    set_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) begin
      idle();
      tick();
    end
  endtask

  // Memory-controller model: 32-bit little-endian access split into two words.
  task automatic ctrl_write32(input logic [18:0] byte_adr, input logic [31:0] d);
    wr(byte_adr[18:1], d[15:0], 1'b0, 1'b0);
    tick();
    wr(byte_adr[18:1] + 18'd1, d[31:16], 1'b0, 1'b0);
    tick();
  endtask

  task automatic ctrl_read32(input logic [18:0] byte_adr, output logic [31:0] d);
    rd(byte_adr[18:1], 1'b0, 1'b0);
    d[15:0] = dq0;
    tick();
    rd(byte_adr[18:1] + 18'd1, 1'b0, 1'b0);
    d[31:16] = dq0;
    tick();
  endtask

  logic [15:0] pre_val [4]  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [17:0] b2b_adr [6]  = '{18'd6, 18'd7, 18'd8, 18'd9, 18'd9, 18'd9};
  logic [15:0] b2b_exp2 [6] = '{16'hAB34, 16'hFFFF, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] b2b_exp0 [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h4444, 16'h4444};
  logic [31:0] rd32;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst_wr_count", 32'(wr0), 32'h0);
    check("rst_rd_count", 32'(rd0), 32'h0);
    check("rst_oor_err", 32'(oor0), 32'h0);
    check("rst_conflict", 32'(cf2), 32'h0);
    check("rst_dq_release", 32'(dq0), 32'hFFFF);
    rst = 1'b0;

    // Full-word write then zero-latency read.
    wr(18'd5, 16'h1234, 1'b0, 1'b0);
    tick();
    rd(18'd5, 1'b0, 1'b0);
    check("l0_read_same_cycle", 32'(dq0), 32'h1234);
    tick();
    check("l0_wr_count", 32'(wr0), 32'd1);
    check("l0_rd_count", 32'(rd0), 32'd1);

    // Upper-lane-only write, then full and lower-masked reads.
    wr(18'd5, 16'hABCD, 1'b0, 1'b1);
    tick();
    rd(18'd5, 1'b0, 1'b0);
    check("lane_ub_write", 32'(dq0), 32'hAB34);
    check("l2_first_return", 32'(dq2), 32'h1234);
    tick();
    rd(18'd5, 1'b0, 1'b1);
    check("lane_lb_masked_read", 32'(dq0), 32'hAB00);
    check("l2_no_return_after_write", 32'(dq2), 32'hFFFF);
    tick();
    flush();
    check("counts_wr", 32'(wr2), 32'd2);
    check("counts_rd", 32'(rd2), 32'd3);

    // Latency 2 and back-to-back streaming.
    for (int k = 0; k < 4; k++) begin
      wr(18'd6 + 18'(k), pre_val[k], 1'b0, 1'b0);
      tick();
    end
    idle();
    tick();
    idle();
    tick();
    rd(18'd5, 1'b0, 1'b0);
    check("l2_cycle_n_release", 32'(dq2), 32'hFFFF);
    tick();
    idle();
    check("l2_cycle_n1_release", 32'(dq2), 32'hFFFF);
    tick();
    for (int j = 0; j < 6; j++) begin
      rd(b2b_adr[j], 1'b0, 1'b0);
      check($sformatf("b2b_l2_%0d", j), 32'(dq2), 32'(b2b_exp2[j]));
      check($sformatf("b2b_l0_%0d", j), 32'(dq0), 32'(b2b_exp0[j]));
      tick();
    end
    flush();
    check("b2b_wr_count", 32'(wr2), 32'd6);
    check("b2b_rd_count", 32'(rd2), 32'd10);

    // Out-of-range access with ADDR_W=10.
    wr(18'd0, 16'h0A0A, 1'b0, 1'b0);
    tick();
    check("oor_clear_before", 32'(oor0), 32'h0);
    wr(18'h00400, 16'h5555, 1'b0, 1'b0);
    tick();
    check("oor_err_set", 32'(oor0), 32'h1);
    rd(18'd0, 1'b0, 1'b0);
    check("oor_write_dropped", 32'(dq0), 32'h0A0A);
    tick();
    rd(18'h00400, 1'b0, 1'b0);
    check("oor_read_data", 32'(dq0), 32'h0000);
    tick();
    flush();
    check("oor_err_sticky", 32'(oor2), 32'h1);

    // Closed loop through the controller model.
    ctrl_write32(19'd1024, 32'hDEADBEEF);
    rd(18'd512, 1'b0, 1'b0);
    check("ctrl_word0", 32'(dq0), 32'hBEEF);
    tick();
    rd(18'd513, 1'b0, 1'b0);
    check("ctrl_word1", 32'(dq0), 32'hDEAD);
    tick();
    ctrl_read32(19'd1024, rd32);
    check("ctrl_read32", rd32, 32'hDEADBEEF);
    flush();

    // Write arriving while a latency-2 return is due.
    check("conflict_clear_before", 32'(cf2), 32'h0);
    rd(18'd5, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    set_bus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'd5, 16'h0000);
    check("conflict_dq_release", 32'(dq2), 32'hFFFF);
    tick();
    check("conflict_flag_l2", 32'(cf2), 32'h1);
    check("conflict_flag_l0", 32'(cf0), 32'h0);
    rd(18'd5, 1'b0, 1'b0);
    check("conflict_masked_write_kept", 32'(dq0), 32'hAB34);
    tick();
    flush();

    // Reset while a return is in flight.
    rd(18'd5, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    rd(18'd5, 1'b0, 1'b0);
    check("rst_cycle_no_drive_l0", 32'(dq0), 32'hFFFF);
    check("rst_cycle_no_drive_l2", 32'(dq2), 32'hFFFF);
    tick();
    rst = 1'b0;
    rd(18'd5, 1'b0, 1'b0);
    check("rst_pipe_flushed", 32'(dq2), 32'hFFFF);
    check("rst_mem_kept", 32'(dq0), 32'hAB34);
    check("rst2_wr_count", 32'(wr2), 32'h0);
    check("rst2_rd_count", 32'(rd2), 32'h0);
    check("rst2_oor_err", 32'(oor2), 32'h0);
    check("rst2_conflict", 32'(cf2), 32'h0);
    tick();
    check("post_rst_rd_count", 32'(rd2), 32'd1);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
